// File: rtl/dense_pkg.sv
// Shared types, widths and FSM state encoding for the dense neuron MAC/requantize engine.
package dense_pkg;

  localparam int unsigned ACC_W      = 32;
  localparam int unsigned ROUND_BASE = 31;

  typedef logic signed [7:0]       act_t;
  typedef logic signed [15:0]      diff_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [63:0]      prod64_t;

  typedef enum logic [1:0] {
    ACCUM,
    MUL,
    RND,
    OUT
  } dense_state_e;

endpackage

// File: rtl/dense_requant.sv
// Combinational ReLU, 64-bit requant multiply, rounding shift and output zero-point add.
// DENSE_SATURATE_EN clamps the 16-bit result to int8 instead of truncating it.
module dense_requant
  import dense_pkg::*;
#(
  parameter int MAX_SHIFT = 30
) (
  input  acc_t               acc_f,
  input  logic               linear,
  input  logic signed [31:0] mult,
  input  logic signed [31:0] shift,
  input  prod64_t            p64,
  input  act_t               output_zp,
  output prod64_t            product_c,
  output act_t               data_c
);

  acc_t       relu;
  logic [5:0] sh;
  logic [5:0] ts;
  prod64_t    rnd;
  diff_t      s16;
  diff_t      o16;

  // Multiply stage feeds the MUL register in the parent.
  always_comb begin
    relu      = (!linear && (acc_f < 0)) ? '0 : acc_f;
    product_c = prod64_t'(relu) * prod64_t'(mult);
  end

  // Out-of-range shifts are pinned into the legal window so the shifter never sees a bad amount.
  always_comb begin
    if (shift < 0) begin
      sh = 6'd0;
    end else if (shift > MAX_SHIFT) begin
      sh = 6'(MAX_SHIFT);
    end else begin
      sh = 6'(shift);
    end
    ts  = 6'(ROUND_BASE) - sh;
    rnd = prod64_t'(1) << (ts - 6'd1);
    s16 = diff_t'((p64 + rnd) >>> ts);
    o16 = s16 + diff_t'(output_zp);
`ifdef DENSE_SATURATE_EN
    if (o16 > 16'sd127) begin
      data_c = act_t'(127);
    end else if (o16 < -16'sd128) begin
      data_c = act_t'(-128);
    end else begin
      data_c = act_t'(o16);
    end
`else
    data_c = act_t'(o16);
`endif
  end

endmodule

// File: rtl/dense_neuron_engine.sv
// Streams int8 activation/weight pairs into a zero-point-corrected MAC and emits one requantized int8.
// Optional DENSE_SATURATE_EN selects int8 clamping in the requant stage.
module dense_neuron_engine
  import dense_pkg::*;
#(
  parameter int MAX_SHIFT = 30
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic signed [7:0]  i_input_zp,
  input  logic signed [7:0]  i_filter_zp,
  input  logic signed [7:0]  i_output_zp,
  input  logic signed [31:0] i_quant_mult,
  input  logic signed [31:0] i_quant_shift,
  input  logic               i_linear,
  input  logic signed [31:0] i_bias,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic signed [7:0]  i_act,
  input  logic signed [7:0]  i_wgt,
  input  logic               i_last,
  output logic               o_valid,
  input  logic               i_ready,
  output logic signed [7:0]  o_data,
  output logic               o_busy
);

  dense_state_e state;
  acc_t         acc;
  prod64_t      p64;

  diff_t   act_diff;
  diff_t   wgt_diff;
  acc_t    prod;
  acc_t    acc_sum;
  acc_t    acc_fin;
  logic    accept;
  prod64_t product_c;
  act_t    data_c;

  // Zero-point-corrected product and running sums for the current beat.
  always_comb begin
    act_diff = diff_t'(i_act) - diff_t'(i_input_zp);
    wgt_diff = diff_t'(i_wgt) - diff_t'(i_filter_zp);
    prod     = acc_t'(act_diff) * acc_t'(wgt_diff);
    acc_sum  = acc + prod;
    acc_fin  = acc_sum + i_bias;
    accept   = i_valid && o_ready && (state == ACCUM);
  end

  // acc holds acc_f once the last beat lands, so the requant multiply reads it directly.
  dense_requant #(
    .MAX_SHIFT(MAX_SHIFT)
  ) u_requant (
    .acc_f    (acc),
    .linear   (i_linear),
    .mult     (i_quant_mult),
    .shift    (i_quant_shift),
    .p64      (p64),
    .output_zp(i_output_zp),
    .product_c(product_c),
    .data_c   (data_c)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ACCUM;
      acc     <= '0;
      p64     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          o_ready <= 1'b1;
          if (accept) begin
            if (i_last) begin
              acc     <= acc_fin;
              state   <= MUL;
              o_ready <= 1'b0;
              o_busy  <= 1'b1;
            end else begin
              acc    <= acc_sum;
              o_busy <= (acc_sum != '0);
            end
          end
        end
        MUL: begin
          p64   <= product_c;
          state <= RND;
        end
        RND: begin
          o_data  <= data_c;
          o_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            acc     <= '0;
            state   <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_neuron_engine.sv
// Directed bench for dense_neuron_engine: literal expectations plus an arithmetic reference model.
module tb_dense_neuron_engine;

  logic               i_clk;
  logic               i_rst;
  logic signed [7:0]  i_input_zp;
  logic signed [7:0]  i_filter_zp;
  logic signed [7:0]  i_output_zp;
  logic signed [31:0] i_quant_mult;
  logic signed [31:0] i_quant_shift;
  logic               i_linear;
  logic signed [31:0] i_bias;
  logic               i_valid;
  logic               o_ready;
  logic signed [7:0]  i_act;
  logic signed [7:0]  i_wgt;
  logic               i_last;
  logic               o_valid;
  logic               i_ready;
  logic signed [7:0]  o_data;
  logic               o_busy;

  int checks = 0;
  int errors = 0;

  logic signed [7:0] acts[16];
  logic signed [7:0] wgts[16];

  dense_neuron_engine #(.MAX_SHIFT(30)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_input_zp   (i_input_zp),
    .i_filter_zp  (i_filter_zp),
    .i_output_zp  (i_output_zp),
    .i_quant_mult (i_quant_mult),
    .i_quant_shift(i_quant_shift),
    .i_linear     (i_linear),
    .i_bias       (i_bias),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_act        (i_act),
    .i_wgt        (i_wgt),
    .i_last       (i_last),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_busy       (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: real-number rounding of acc_f * mult / 2^(31-shift), half rounded up.
  function automatic logic signed [7:0] model(input int acc_f, input bit lin, input int mult,
                                              input int shift, input int ozp);
    longint  r;
    longint  p;
    longint  s;
    int      ts;
    shortint o;
    r  = (lin || acc_f >= 0) ? longint'(acc_f) : 64'sd0;
    p  = r * longint'(mult);
    ts = 31 - shift;
    s  = p >>> ts;
    if (p[ts-1]) s = s + 1;
    o  = shortint'(s) + shortint'(ozp);
`ifdef DENSE_SATURATE_EN
    if (o > 127) o = 127;
    else if (o < -128) o = -128;
`endif
    return o[7:0];
  endfunction

  // Per-cycle monitor: tracks accepted beats, predicts results and latency, checks outputs.
  int                cyc = 0;
  int                exp_rise = -1;
  bit                prev_v = 1'b0;
  int                acc_m = 0;
  logic signed [7:0] q[$];

  always @(negedge i_clk) begin
    cyc++;
    if (i_rst) begin
      acc_m    = 0;
      q.delete();
      exp_rise = -1;
      prev_v   = 1'b0;
      chk("rst_valid", longint'(o_valid), 0);
      chk("rst_ready", longint'(o_ready), 0);
      chk("rst_data", longint'(o_data), 0);
    end else begin
      if (o_valid) begin
        chk("out_ready_low", longint'(o_ready), 0);
        if (!prev_v) chk("latency", cyc, exp_rise);
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("model_data", longint'(o_data), longint'(q[0]));
          if (i_ready) void'(q.pop_front());
        end
      end
      if (i_valid && o_ready) begin
        acc_m = acc_m + (int'(i_act) - int'(i_input_zp)) * (int'(i_wgt) - int'(i_filter_zp));
        if (i_last) begin
          q.push_back(model(acc_m + i_bias, i_linear, i_quant_mult, i_quant_shift,
                            int'(i_output_zp)));
          acc_m    = 0;
          exp_rise = cyc + 3;
        end
      end
      prev_v = o_valid;
    end
  end

  task automatic send_neuron(input int n, input bit with_last);
    int g;
    for (int i = 0; i < n; i++) begin
      i_act   = acts[i];
      i_wgt   = wgts[i];
      i_last  = with_last && (i == n - 1);
      i_valid = 1'b1;
      g = 0;
      while (!o_ready && g < 20) begin
        @(posedge i_clk); #1;
        g++;
      end
      if (!o_ready) chk("ready_timeout", 0, 1);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic get_result(input string name, input int hold, input bit use_lit,
                            input logic signed [7:0] lit);
    int g;
    g = 0;
    while (!o_valid && g < 20) begin
      @(posedge i_clk); #1;
      g++;
    end
    chk({name, "_valid"}, longint'(o_valid), 1);
    if (use_lit) chk(name, longint'(o_data), longint'(lit));
    chk({name, "_busy"}, longint'(o_busy), 1);
    if (hold > 0) begin
      i_valid = 1'b1;
      i_last  = 1'b1;
      i_act   = 8'sd77;
      i_wgt   = -8'sd9;
      repeat (hold) begin
        @(posedge i_clk); #1;
        chk("bp_ready", longint'(o_ready), 0);
        chk("bp_valid", longint'(o_valid), 1);
      end
      i_valid = 1'b0;
      i_last  = 1'b0;
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    chk({name, "_turn_ready"}, longint'(o_ready), 1);
    chk({name, "_turn_valid"}, longint'(o_valid), 0);
    chk({name, "_turn_busy"}, longint'(o_busy), 0);
  endtask

  task automatic set_cfg(input int izp, input int fzp, input int ozp, input int mult,
                         input int shift, input bit lin, input int bias);
    i_input_zp    = 8'(izp);
    i_filter_zp   = 8'(fzp);
    i_output_zp   = 8'(ozp);
    i_quant_mult  = mult;
    i_quant_shift = shift;
    i_linear      = lin;
    i_bias        = bias;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_last  = 1'b0;
    i_act   = '0;
    i_wgt   = '0;
    set_cfg(0, 0, 0, 32'h4000_0000, 0, 1'b1, 0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_busy", longint'(o_busy), 0);
    chk("reset_ready", longint'(o_ready), 0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("post_reset_ready", longint'(o_ready), 1);
    chk("post_reset_busy", longint'(o_busy), 0);

    // Single beat: 10*3 = 30 -> 15.
    acts[0] = 8'sd10; wgts[0] = 8'sd3;
    send_neuron(1, 1'b1);
    get_result("single", 0, 1'b1, 8'sd15);

    // Zero points with backpressure while a beat is offered.
    set_cfg(-3, 1, -128, 32'h4000_0000, 0, 1'b1, -4);
    for (int i = 0; i < 3; i++) begin acts[i] = 8'sd5; wgts[i] = 8'sd2; end
    send_neuron(3, 1'b1);
    get_result("zero_points", 5, 1'b1, -8'sd118);

    // ReLU path on acc_f = -100.
    set_cfg(0, 0, 5, 32'h4000_0000, 0, 1'b0, 0);
    acts[0] = -8'sd100; wgts[0] = 8'sd1;
    send_neuron(1, 1'b1);
    get_result("relu_on", 0, 1'b1, 8'sd5);
    i_linear = 1'b1;
    send_neuron(1, 1'b1);
    get_result("relu_off", 0, 1'b1, -8'sd45);

    // Overflow of the int8 range: 1000 -> 500.
    set_cfg(0, 0, 0, 32'h4000_0000, 0, 1'b1, 0);
    acts[0] = 8'sd100; wgts[0] = 8'sd10;
    send_neuron(1, 1'b1);
`ifdef DENSE_SATURATE_EN
    get_result("overflow", 0, 1'b1, 8'sd127);
`else
    get_result("overflow", 0, 1'b1, -8'sd12);
`endif

    // Reset after 4 of 10 beats, then a fresh single beat.
    for (int i = 0; i < 10; i++) begin acts[i] = 8'sd50; wgts[i] = 8'sd60; end
    send_neuron(4, 1'b0);
    chk("mid_busy", longint'(o_busy), 1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_ready", longint'(o_ready), 0);
    chk("mid_rst_valid", longint'(o_valid), 0);
    chk("mid_rst_busy", longint'(o_busy), 0);
    repeat (2) begin @(posedge i_clk); #1; end
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("mid_rst_ready_back", longint'(o_ready), 1);
    acts[0] = 8'sd10; wgts[0] = 8'sd3;
    send_neuron(1, 1'b1);
    get_result("after_reset", 0, 1'b1, 8'sd15);

    // Model-checked vectors with varied shifts, signs and zero points.
    for (int k = 0; k < 6; k++) begin
      int n;
      n = 1 + int'($urandom_range(7, 0));
      set_cfg(int'($urandom_range(20, 0)) - 10, int'($urandom_range(20, 0)) - 10,
              int'($urandom_range(60, 0)) - 30, int'($urandom), int'($urandom_range(30, 0)),
              1'($urandom_range(1, 0)), int'($urandom_range(200000, 0)) - 100000);
      for (int i = 0; i < n; i++) begin
        acts[i] = 8'($urandom);
        wgts[i] = 8'($urandom);
      end
      send_neuron(n, 1'b1);
      get_result("model_vec", int'($urandom_range(3, 0)), 1'b0, 8'sd0);
    end

    repeat (4) @(posedge i_clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dense_neuron_engine.md
# dense_neuron_engine

Hardware counterpart of the software MAC/requantize loop used by the quantized MNIST flow. It accepts a stream of int8 activation/weight pairs for one output neuron and accumulates zero-point-corrected products into a 32-bit sum. It then adds the int32 bias, applies optional ReLU and fixed-point requantization, and emits one int8 result over a valid/ready handshake. Results are bit-exact with the layer output files produced by the golden model (default build). It sits between the layer operand fetch logic and the activation write-back buffer.

## Interface
- `MAX_SHIFT`, default 30: largest legal `i_quant_shift`.
- `i_clk`  in  1  sole clock, rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_input_zp`, `i_filter_zp`, `i_output_zp`  in  8 each  signed zero points.
- `i_quant_mult`  in  32  signed requant multiplier.
- `i_quant_shift`  in  32  signed; legal range 0..`MAX_SHIFT`.
- `i_linear`  in  1  1 = no activation, 0 = ReLU.
- `i_bias`  in  32  signed bias, sampled with the last beat.
- `i_valid`  in  1  operand beat valid.
- `o_ready`  out  1  engine accepts beats.
- `i_act`, `i_wgt`  in  8 each  signed activation and weight.
- `i_last`  in  1  final beat of this neuron.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  downstream accepts result.
- `o_data`  out  8  signed int8 result.
- `o_busy`  out  1  high whenever the engine is not in `ACCUM` with zero accumulator.

## Operation
- **Beat acceptance:** a beat is accepted on a rising edge where `i_valid && o_ready`.
- **States:**
  - `ACCUM`: `o_ready`=1.
  - `MUL`, `RND`: `o_ready`=0.
  - `OUT`: `o_ready`=0, `o_valid`=1.
- **ACCUM:**
  - Each accepted beat: `acc += (act - input_zp) * (wgt - filter_zp)`.
  - Operand differences are 16-bit signed, the product is 32-bit signed, and `acc` is 32-bit wrapping.
  - A beat with `i_last`: `acc_f = acc + prod + i_bias`, then go to `MUL`. Every neuron has at least one beat.
- **MUL:**
  - `r = i_linear ? acc_f : (acc_f < 0 ? 0 : acc_f)`.
  - `p64 = r * i_quant_mult`, signed 64-bit, registered. Go to `RND`.
- **RND:**
  - `ts = 31 - i_quant_shift`.
  - `s = (p64 + (1 << (ts-1))) >>> ts`, arithmetic shift.
  - `o16 = s[15:0] + output_zp`; `o_data = o16[7:0]`. Go to `OUT`.
- **OUT:** hold `o_data` and `o_valid` until `i_ready`. On handshake: `acc`=0, go to `ACCUM`.
- **Input stability:** config inputs must be stable from the first beat until the output handshake completes.
- **Out of range:** `i_quant_shift` outside the legal range gives an undefined result, with no hang.

## Timing
- **Reset values:** `o_valid`=0, `o_data`=0, `o_ready`=0 while `i_rst` is high. State=`ACCUM`, `acc`=0, `o_busy`=0. `o_ready` is 1 on the first cycle after reset deasserts.
- **Throughput:** one beat per cycle in `ACCUM`.
- **Latency:** with the last beat accepted at edge E, `o_valid` rises after edge E+2. It is observable in the cycle following E+2.
- **Backpressure:** while `i_ready`=0, `o_valid` and `o_data` are stable and no beats are accepted.
- **Turnaround:** `o_ready` returns high in the cycle after the output handshake edge. Minimum neuron period is N beats + 3 cycles.
- **Reset mid-operation:** the partial sum and any pending result are discarded immediately.

## Configuration
- **`DENSE_SATURATE_EN` defined:** `o16` is clamped to [-128, 127] before the 8-bit output is taken.
- **`DENSE_SATURATE_EN` undefined (default):** plain truncation to `o16[7:0]`, bit-exact with the golden layer outputs.

## Structure
- Package `dense_pkg` holds:
  - `act_t` (signed 8), `diff_t` (signed 16), `acc_t` (signed 32), `prod64_t` (signed 64).
  - State enum `dense_state_e` {`ACCUM`, `MUL`, `RND`, `OUT`}.
  - `ACC_W`=32 and `ROUND_BASE`=31.
- Sub-module `dense_requant` contains the ReLU, 64-bit multiply, rounding shift, zero-point add and saturation. It is combinational with the `MUL`/`RND` registers in the parent.

## Test plan
- **Single beat:** act=10, wgt=3, all zp=0, bias=0, mult=0x40000000, shift=0 -> `o_data`=15, `o_valid` after edge E+2.
- **Zero points:** 3 beats act=5, wgt=2; input_zp=-3, filter_zp=1, bias=-4, output_zp=-128, same quant -> `o_data`=0x8A (-118).
- **ReLU path:** single beat giving `acc_f`=-100, output_zp=5, mult=0x40000000, shift=0.
  - `i_linear`=0 -> 5.
  - `i_linear`=1 -> -45.
- **Backpressure:** hold `i_ready`=0 for 5 cycles in `OUT` with `i_valid`=1 -> `o_data` stable, `o_ready`=0, no beat consumed. The next neuron's result is unaffected.
- **Overflow:** `acc_f`=1000, mult=0x40000000, shift=0, output_zp=0.
  - Without `DENSE_SATURATE_EN` -> 0xF4.
  - With `DENSE_SATURATE_EN` -> 0x7F.
- **Reset mid-accumulation:** assert `i_rst` after 4 of 10 beats, then run a fresh single-beat vector (act=10, wgt=3) -> 15. `o_valid`=0 and `o_ready`=0 during reset.
